// File: rtl/dma_arb_pkg.sv
// Shared types and limits for the DMA channel arbiter.
package dma_arb_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } arb_state_t;

  typedef enum logic {
    FIXED    = 1'b0,
    ROTATING = 1'b1
  } priority_type_t;

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational priority picker: returns the first set request found when
// scanning upward from startPtr and wrapping modulo NUM_CH. With rotate low
// the scan always starts at channel 0 (fixed priority).
module dma_rr_picker #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   startPtr,
  input  logic              rotate,
  output logic              found,
  output logic [CH_W-1:0]   winner
);

  localparam logic [CH_W:0] NUM_CH_W = (CH_W+1)'(NUM_CH);

  logic [CH_W-1:0] start_eff;

  assign start_eff = rotate ? startPtr : '0;

  // Wrapped scan; the extra index bit holds start+offset before the modulo fold.
  always_comb begin
    logic [CH_W:0]   idx_wide;
    logic [CH_W-1:0] idx;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_wide = {1'b0, start_eff} + (CH_W+1)'(i);
      if (idx_wide >= NUM_CH_W) begin
        idx_wide = idx_wide - NUM_CH_W;
      end
      idx = idx_wide[CH_W-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: merges masked hardware requests with software requests,
// raises HRQ to the timing FSM, grants one channel when the bus is acquired and
// holds that grant until the transfer completes.
module dma_channel_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic [NUM_CH-1:0] swReq,
  input  logic              priorityType,
  input  logic              dreqSenseLow,
  input  logic              dackSenseHigh,
  input  logic              assertDACK,
  input  logic              transferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic              grantValid,
  output logic [CH_W-1:0]   grantCh
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  arb_state_t        state_q, state_d;
  logic [CH_W-1:0]   top_ptr_q, top_ptr_d;
  logic [CH_W-1:0]   grant_ch_q, grant_ch_d;
  logic              grant_valid_q, grant_valid_d;
  logic [NUM_CH-1:0] dack_raw_q, dack_raw_d;
  logic              hrq_q, hrq_d;

  logic [NUM_CH-1:0] eff_req;
  logic              rotate;
  logic              pick_found;
  logic [CH_W-1:0]   pick_winner;

  assign eff_req = ((DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg) | swReq;
  assign rotate  = (priority_type_t'(priorityType) == ROTATING);

  dma_rr_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .req      (eff_req),
    .startPtr (top_ptr_q),
    .rotate   (rotate),
    .found    (pick_found),
    .winner   (pick_winner)
  );

  // Next-state, grant capture and priority pointer update.
  always_comb begin
    state_d       = state_q;
    top_ptr_d     = top_ptr_q;
    grant_ch_d    = grant_ch_q;
    grant_valid_d = grant_valid_q;
    dack_raw_d    = dack_raw_q;
    unique case (state_q)
      IDLE: begin
        if (|eff_req) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (!(|eff_req)) begin
          state_d = IDLE;
        end else if (assertDACK && pick_found) begin
          state_d       = SERVICE;
          grant_ch_d    = pick_winner;
          grant_valid_d = 1'b1;
          dack_raw_d    = NUM_CH'(1) << pick_winner;
        end
      end
      SERVICE: begin
        // Grant is frozen here; only transfer completion releases it.
        if (transferDone) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
          dack_raw_d    = '0;
          if (rotate) begin
            top_ptr_d = (grant_ch_q == LAST_CH) ? '0 : grant_ch_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    hrq_d = (state_d == REQ) || (state_d == SERVICE);
  end

  // State, pointer and grant registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      top_ptr_q     <= '0;
      grant_ch_q    <= '0;
      grant_valid_q <= 1'b0;
      dack_raw_q    <= '0;
      hrq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      top_ptr_q     <= top_ptr_d;
      grant_ch_q    <= grant_ch_d;
      grant_valid_q <= grant_valid_d;
      dack_raw_q    <= dack_raw_d;
      hrq_q         <= hrq_d;
    end
  end

  // Sense is applied after the register so a polarity change moves DACK at once.
  assign DACK       = dackSenseHigh ? dack_raw_q : ~dack_raw_q;
  assign HRQ        = hrq_q;
  assign grantValid = grant_valid_q;
  assign grantCh    = grant_ch_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter: a 4-channel and a 5-channel instance.
module tb_dma_channel_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [3:0] DREQ, maskReg, swReq;
  logic       priorityType, dreqSenseLow, dackSenseHigh, assertDACK, transferDone;
  logic       HRQ, grantValid;
  logic [3:0] DACK;
  logic [1:0] grantCh;

  logic [4:0] DREQ5, mask5, sw5;
  logic       prio5, senseLow5, senseHigh5, asrt5, td5;
  logic       HRQ5, gv5;
  logic [4:0] DACK5;
  logic [2:0] gch5;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         ch;
    logic [4:0] dack;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  dma_channel_arbiter #(.NUM_CH(4)) dut4 (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .maskReg(maskReg), .swReq(swReq),
    .priorityType(priorityType), .dreqSenseLow(dreqSenseLow),
    .dackSenseHigh(dackSenseHigh), .assertDACK(assertDACK),
    .transferDone(transferDone), .HRQ(HRQ), .DACK(DACK),
    .grantValid(grantValid), .grantCh(grantCh)
  );

  dma_channel_arbiter #(.NUM_CH(5)) dut5 (
    .CLK(CLK), .RESET(RESET), .DREQ(DREQ5), .maskReg(mask5), .swReq(sw5),
    .priorityType(prio5), .dreqSenseLow(senseLow5),
    .dackSenseHigh(senseHigh5), .assertDACK(asrt5),
    .transferDone(td5), .HRQ(HRQ5), .DACK(DACK5),
    .grantValid(gv5), .grantCh(gch5)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_hrq(input bit sel, input string tag);
    int n = 0;
    while (((sel ? HRQ5 : HRQ) !== 1'b1) && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_hrq"}, 32'(sel ? HRQ5 : HRQ), 32'd1);
  endtask

  task automatic serve(input bit sel, input int ch, input logic [4:0] dack, input string tag);
    exp_t e;
    wait_hrq(sel, tag);
    sb.push_back('{ch, dack});
    if (sel) asrt5 = 1'b1;
    else     assertDACK = 1'b1;
    tick();
    asrt5      = 1'b0;
    assertDACK = 1'b0;
    e = sb.pop_front();
    chk({tag, "_ch"},   32'(sel ? gch5 : {1'b0, grantCh}), 32'(e.ch));
    chk({tag, "_dack"}, 32'(sel ? DACK5 : {1'b0, DACK}),   32'(e.dack));
    chk({tag, "_gv"},   32'(sel ? gv5 : grantValid),       32'd1);
  endtask

  task automatic end_svc(input bit sel, input logic [4:0] idle_dack, input string tag);
    if (sel) td5 = 1'b1;
    else     transferDone = 1'b1;
    tick();
    td5          = 1'b0;
    transferDone = 1'b0;
    chk({tag, "_done_gv"},   32'(sel ? gv5 : grantValid),     32'd0);
    chk({tag, "_done_dack"}, 32'(sel ? DACK5 : {1'b0, DACK}), 32'(idle_dack));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    DREQ = '0; maskReg = '0; swReq = '0;
    priorityType = 1'b0; dreqSenseLow = 1'b0; dackSenseHigh = 1'b1;
    assertDACK = 1'b0; transferDone = 1'b0;
    DREQ5 = '0; mask5 = '0; sw5 = '0;
    prio5 = 1'b1; senseLow5 = 1'b0; senseHigh5 = 1'b1; asrt5 = 1'b0; td5 = 1'b0;
    tick();
    tick();
    chk("rst_hrq",  32'(HRQ),        32'd0);
    chk("rst_gv",   32'(grantValid), 32'd0);
    chk("rst_ch",   32'(grantCh),    32'd0);
    chk("rst_dack", 32'(DACK),       32'd0);
    chk("rst_dack5", 32'(DACK5),     32'd0);
    RESET = 1'b0;

    // Test 1: fixed priority, lowest set index wins repeatedly
    DREQ = 4'b1010;
    serve(1'b0, 1, 5'b00010, "t1a");
    end_svc(1'b0, 5'b00000, "t1a");
    serve(1'b0, 1, 5'b00010, "t1b");
    end_svc(1'b0, 5'b00000, "t1b");

    // Test 2: rotating priority, all channels requesting
    priorityType = 1'b1;
    DREQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      serve(1'b0, i % 4, 5'(1 << (i % 4)), $sformatf("t2_%0d", i));
      end_svc(1'b0, 5'b00000, $sformatf("t2_%0d", i));
    end
    DREQ = '0;
    tick();
    tick();

    // Test 4: active-low DREQ, mask, software request, active-low DACK
    priorityType = 1'b0;
    dreqSenseLow = 1'b1;
    DREQ = 4'b1110;
    maskReg = 4'b0001;
    swReq = 4'b1000;
    dackSenseHigh = 1'b0;
    #1;
    chk("t4_idle_dack", 32'(DACK), 32'hF);
    serve(1'b0, 3, 5'b00111, "t4");
    end_svc(1'b0, 5'b01111, "t4");
    dreqSenseLow = 1'b0; DREQ = '0; maskReg = '0; swReq = '0; dackSenseHigh = 1'b1;
    tick();
    tick();
    chk("t4_cleanup_hrq", 32'(HRQ), 32'd0);

    // Test 5: request withdrawn before the grant
    DREQ = 4'b0010;
    tick();
    chk("t5_req_hrq", 32'(HRQ), 32'd1);
    DREQ = 4'b0000;
    tick();
    chk("t5_wd_hrq",  32'(HRQ),        32'd0);
    chk("t5_wd_gv",   32'(grantValid), 32'd0);
    chk("t5_wd_dack", 32'(DACK),       32'd0);
    tick();
    chk("t5_nopulse", 32'(DACK),       32'd0);

    // Test 6: reset in the middle of a ch2 service (pointer was 1 from test 2)
    priorityType = 1'b1;
    DREQ = 4'b0100;
    serve(1'b0, 2, 5'b00100, "t6");
    RESET = 1'b1;
    assertDACK = 1'b1;
    tick();
    RESET = 1'b0;
    assertDACK = 1'b0;
    chk("t6_rst_dack", 32'(DACK),       32'd0);
    chk("t6_rst_gv",   32'(grantValid), 32'd0);
    chk("t6_rst_hrq",  32'(HRQ),        32'd0);
    chk("t6_rst_ch",   32'(grantCh),    32'd0);
    DREQ = 4'b1111;
    serve(1'b0, 0, 5'b00001, "t6_ptr0");
    end_svc(1'b0, 5'b00000, "t6_ptr0");
    DREQ = '0;

    // Test 3: five channels, pointer wraps from 4 back to 0
    DREQ5 = 5'b01000;
    serve(1'b1, 3, 5'b01000, "t3a");
    end_svc(1'b1, 5'b00000, "t3a");
    DREQ5 = 5'b10001;
    serve(1'b1, 4, 5'b10000, "t3b");
    end_svc(1'b1, 5'b00000, "t3b");
    serve(1'b1, 0, 5'b00001, "t3c");
    end_svc(1'b1, 5'b00000, "t3c");
    DREQ5 = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
